// File: rtl/alu_secuencial.sv
// ============================================================================
//  Module   : alu_secuencial
//  Brief    : Multi-cycle ALU; one-clock logic/arith ops, iterative mul/div.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_secuencial #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       SEL,
    output logic [WIDTH-1:0] RESULTADO,
    output logic             ZF,
    output logic             OVF,
    output logic             DIV0,
    output logic             BUSY,
    output logic             DONE
);

    localparam int                  c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_slt  = 3'b100;
    localparam logic [2:0] c_op_mul  = 3'b101;
    localparam logic [2:0] c_op_div  = 3'b110;

    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zf_q, zf_d;
    logic               ovf_q, ovf_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_quot_next;
    logic               w_last;

    assign w_add = {1'b0, A} + {1'b0, B};
    assign w_sub = {1'b0, A} - {1'b0, B};

    // Shift-add: low half holds the remaining multiplier bits, upper half the partial product.
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step; the remainder is always below the divisor, so WIDTH bits suffice to store it.
    assign w_trial     = {rem_q, acc_q[WIDTH-1]};
    assign w_fits      = (w_trial >= {1'b0, b_q});
    assign w_rem_sub   = w_trial[WIDTH-1:0] - b_q;
    assign w_quot_next = {acc_q[WIDTH-2:0], w_fits};

    assign w_last = (cnt_q == c_cnt_one);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (START && SEL == c_op_mul) begin
                    state_d = c_st_mul;
                end else if (START && SEL == c_op_div && B != '0) begin
                    state_d = c_st_div;
                end
            end
            c_st_mul, c_st_div: begin
                if (w_last) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        b_d    = b_q;
        rem_d  = rem_q;
        res_d  = res_q;
        zf_d   = zf_q;
        ovf_d  = ovf_q;
        div0_d = div0_q;
        done_d = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (START) begin
                    b_d    = B;
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                    div0_d = 1'b0;
                    case (SEL)
                        c_op_add: begin
                            res_d = w_add[WIDTH-1:0];
                            ovf_d = w_add[WIDTH];
                        end
                        c_op_sub: begin
                            res_d = w_sub[WIDTH-1:0];
                            ovf_d = w_sub[WIDTH];
                        end
                        c_op_and: res_d = A & B;
                        c_op_or:  res_d = A | B;
                        c_op_slt: res_d = WIDTH'(A < B);
                        c_op_mul: begin
                            done_d = 1'b0;
                            ovf_d  = ovf_q;
                            acc_d  = {{WIDTH{1'b0}}, A};
                            cnt_d  = c_cnt_load;
                        end
                        c_op_div: begin
                            if (B == '0) begin
                                res_d  = '1;
                                div0_d = 1'b1;
                            end else begin
                                done_d = 1'b0;
                                ovf_d  = ovf_q;
                                div0_d = div0_q;
                                acc_d  = {{WIDTH{1'b0}}, A};
                                rem_d  = '0;
                                cnt_d  = c_cnt_load;
                            end
                        end
                        default: res_d = '0;
                    endcase
                end
            end
            c_st_mul: begin
                acc_d = w_mul_next;
                cnt_d = cnt_q - c_cnt_one;
                if (w_last) begin
                    res_d  = w_mul_next[WIDTH-1:0];
                    ovf_d  = |w_mul_next[2*WIDTH-1:WIDTH];
                    div0_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            c_st_div: begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], w_quot_next};
                rem_d = w_fits ? w_rem_sub : w_trial[WIDTH-1:0];
                cnt_d = cnt_q - c_cnt_one;
                if (w_last) begin
                    res_d  = w_quot_next;
                    ovf_d  = 1'b0;
                    div0_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Zero flag always tracks the value being written on a completion edge.
        if (done_d) begin
            zf_d = (res_d == '0);
        end
    end

    assign RESULTADO = res_q;
    assign ZF        = zf_q;
    assign OVF       = ovf_q;
    assign DIV0      = div0_q;
    assign BUSY      = (state_q != c_st_idle);
    assign DONE      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_secuencial.sv
// ============================================================================
//  Module   : tb_alu_secuencial
//  Brief    : Directed vector bench for alu_secuencial at WIDTH 32 and 8.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_secuencial;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
        logic        ovf;
        logic        div0;
        int          lat;
    } vec_t;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;

    logic        START32 = 1'b0;
    logic [31:0] A32 = '0, B32 = '0;
    logic [2:0]  SEL32 = '0;
    logic [31:0] R32;
    logic        ZF32, OVF32, DIV032, BUSY32, DONE32;

    logic        START8 = 1'b0;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [2:0]  SEL8 = '0;
    logic [7:0]  R8;
    logic        ZF8, OVF8, DIV08, BUSY8, DONE8;

    int checks = 0;
    int errors = 0;

    alu_secuencial #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RST_N(RST_N), .START(START32), .A(A32), .B(B32), .SEL(SEL32),
        .RESULTADO(R32), .ZF(ZF32), .OVF(OVF32), .DIV0(DIV032), .BUSY(BUSY32), .DONE(DONE32)
    );

    alu_secuencial #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(START8), .A(A8), .B(B8), .SEL(SEL8),
        .RESULTADO(R8), .ZF(ZF8), .OVF(OVF8), .DIV0(DIV08), .BUSY(BUSY8), .DONE(DONE8)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("done_and_busy_32", 64'(DONE32 & BUSY32), 64'd0);
            chk("done_and_busy_8", 64'(DONE8 & BUSY8), 64'd0);
        end
    end

    task automatic apply32(input string tag, input vec_t v);
        int lat;
        int busy_n;
        @(negedge CLK);
        START32 = 1'b1; SEL32 = v.sel; A32 = v.a; B32 = v.b;
        @(posedge CLK); #1;
        START32 = 1'b0;
        lat = 0; busy_n = 0;
        while (!DONE32 && lat < 200) begin
            if (BUSY32) busy_n++;
            @(posedge CLK); #1;
            lat++;
        end
        chk({tag, ".lat"},  64'(lat), 64'(v.lat));
        chk({tag, ".busy"}, 64'(busy_n), 64'(v.lat));
        chk({tag, ".res"},  64'(R32), 64'(v.res));
        chk({tag, ".zf"},   64'(ZF32), 64'(v.zf));
        chk({tag, ".ovf"},  64'(OVF32), 64'(v.ovf));
        chk({tag, ".div0"}, 64'(DIV032), 64'(v.div0));
        @(posedge CLK); #1;
        chk({tag, ".done_fall"}, 64'(DONE32), 64'd0);
    endtask

    task automatic apply8(input string tag, input vec_t v);
        int lat;
        int busy_n;
        @(negedge CLK);
        START8 = 1'b1; SEL8 = v.sel; A8 = v.a[7:0]; B8 = v.b[7:0];
        @(posedge CLK); #1;
        START8 = 1'b0;
        lat = 0; busy_n = 0;
        while (!DONE8 && lat < 200) begin
            if (BUSY8) busy_n++;
            @(posedge CLK); #1;
            lat++;
        end
        chk({tag, ".lat"},  64'(lat), 64'(v.lat));
        chk({tag, ".busy"}, 64'(busy_n), 64'(v.lat));
        chk({tag, ".res"},  64'(R8), 64'(v.res));
        chk({tag, ".zf"},   64'(ZF8), 64'(v.zf));
        chk({tag, ".ovf"},  64'(OVF8), 64'(v.ovf));
        chk({tag, ".div0"}, 64'(DIV08), 64'(v.div0));
        @(posedge CLK); #1;
        chk({tag, ".done_fall"}, 64'(DONE8), 64'd0);
    endtask

    vec_t v32[15];
    vec_t v8[5];

    initial begin
        int lat;
        int early_done;
        int late_done;

        //             sel     a             b             res           zf ovf d0 lat
        v32[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0};
        v32[1]  = '{3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 1, 0, 0};
        v32[2]  = '{3'b010, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 0, 0, 0, 0};
        v32[3]  = '{3'b011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0};
        v32[4]  = '{3'b100, 32'h00000003, 32'h00000009, 32'h00000001, 0, 0, 0, 0};
        v32[5]  = '{3'b100, 32'h00000009, 32'h00000003, 32'h00000000, 1, 0, 0, 0};
        v32[6]  = '{3'b100, 32'h80000005, 32'h80000005, 32'h00000000, 1, 0, 0, 0};
        v32[7]  = '{3'b111, 32'h00000123, 32'h00000456, 32'h00000000, 1, 0, 0, 0};
        v32[8]  = '{3'b001, 32'h00000007, 32'h00000007, 32'h00000000, 1, 0, 0, 0};
        v32[9]  = '{3'b110, 32'd100,      32'd7,        32'd14,       0, 0, 0, 32};
        v32[10] = '{3'b110, 32'd7,        32'd100,      32'd0,        1, 0, 0, 32};
        v32[11] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 32};
        v32[12] = '{3'b110, 32'd42,       32'd0,        32'hFFFFFFFF, 0, 0, 1, 0};
        v32[13] = '{3'b000, 32'd2,        32'd3,        32'd5,        0, 0, 0, 0};
        v32[14] = '{3'b101, 32'h00010000, 32'h00010003, 32'h00030000, 0, 1, 0, 32};

        v8[0] = '{3'b101, 32'd15,  32'd17,  32'd255,  0, 0, 0, 8};
        v8[1] = '{3'b101, 32'd16,  32'd16,  32'd0,    1, 1, 0, 8};
        v8[2] = '{3'b101, 32'd13,  32'd11,  32'h8F,   0, 0, 0, 8};
        v8[3] = '{3'b101, 32'd255, 32'd255, 32'h01,   0, 1, 0, 8};
        v8[4] = '{3'b110, 32'd200, 32'd9,   32'd22,   0, 0, 0, 8};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset.res32",  64'(R32), 64'd0);
        chk("reset.flags32", 64'({ZF32, OVF32, DIV032, BUSY32, DONE32}), 64'd0);
        chk("reset.res8",   64'(R8), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 15; i++) apply32($sformatf("v32[%0d]", i), v32[i]);
        for (int i = 0; i < 5; i++)  apply8($sformatf("v8[%0d]", i), v8[i]);

        // START and operand changes mid-multiply must be ignored.
        @(negedge CLK);
        START8 = 1'b1; SEL8 = 3'b101; A8 = 8'd15; B8 = 8'd17;
        @(posedge CLK); #1;
        START8 = 1'b0;
        lat = 0; early_done = 0;
        repeat (3) begin @(posedge CLK); #1; lat++; early_done += int'(DONE8); end
        START8 = 1'b1; SEL8 = 3'b000; A8 = 8'd1; B8 = 8'd2;
        repeat (2) begin @(posedge CLK); #1; lat++; early_done += int'(DONE8); end
        START8 = 1'b0;
        while (!DONE8 && lat < 200) begin @(posedge CLK); #1; lat++; end
        chk("midmul.early_done", 64'(early_done), 64'd0);
        chk("midmul.lat", 64'(lat), 64'd8);
        chk("midmul.res", 64'(R8), 64'd255);
        chk("midmul.ovf", 64'(OVF8), 64'd0);
        late_done = 0;
        repeat (12) begin @(posedge CLK); #1; late_done += int'(DONE8); end
        chk("midmul.extra_done", 64'(late_done), 64'd0);

        // New START raised during the DONE cycle of a divide.
        @(negedge CLK);
        START32 = 1'b1; SEL32 = 3'b110; A32 = 32'd100; B32 = 32'd7;
        @(posedge CLK); #1;
        START32 = 1'b0;
        lat = 0;
        while (!DONE32 && lat < 200) begin @(posedge CLK); #1; lat++; end
        chk("b2b.div_lat", 64'(lat), 64'd32);
        chk("b2b.div_res", 64'(R32), 64'd14);
        START32 = 1'b1; SEL32 = 3'b000; A32 = 32'd2; B32 = 32'd3;
        @(posedge CLK); #1;
        START32 = 1'b0;
        chk("b2b.add_done", 64'(DONE32), 64'd1);
        chk("b2b.add_res", 64'(R32), 64'd5);
        chk("b2b.add_busy", 64'(BUSY32), 64'd0);
        @(posedge CLK); #1;
        chk("b2b.done_fall", 64'(DONE32), 64'd0);

        // Asynchronous reset at iteration 10 of a 32-cycle divide.
        @(negedge CLK);
        START32 = 1'b1; SEL32 = 3'b110; A32 = 32'd100; B32 = 32'd7;
        @(posedge CLK); #1;
        START32 = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        chk("rstdiv.busy_before", 64'(BUSY32), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("rstdiv.res", 64'(R32), 64'd0);
        chk("rstdiv.flags", 64'({ZF32, OVF32, DIV032, BUSY32, DONE32}), 64'd0);
        chk("rstdiv.res8", 64'(R8), 64'd0);
        late_done = 0;
        repeat (2) begin @(negedge CLK); late_done += int'(DONE32); end
        RST_N = 1'b1;
        repeat (40) begin @(posedge CLK); #1; late_done += int'(DONE32); end
        chk("rstdiv.no_done", 64'(late_done), 64'd0);
        apply32("after_rst_add", '{3'b000, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
